// File: rtl/exe_div_unit.sv
// exe_div_unit: iterative RISC-V DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
//   clk, reset (sync, active-high), recover_i (flush of the in-flight op)
//   in_valid_i, in_op_i (0=DIV 1=DIVU 2=REM 3=REMU), src1_i (dividend), src2_i (divisor),
//   phy_dest_i, phy_dest_valid_i, al_id_i : operand bundle from register read
//   busy_o : unit occupied, issue must hold off
//   out_valid_o (one-cycle pulse), out_data_o, out_phy_dest_o, out_phy_dest_valid_o, out_al_id_o
module exe_div_unit #(
    parameter int DATA_W  = 32,
    parameter int PHY_LOG = 7,
    parameter int AL_LOG  = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               recover_i,
    input  logic               in_valid_i,
    input  logic [1:0]         in_op_i,
    input  logic [DATA_W-1:0]  src1_i,
    input  logic [DATA_W-1:0]  src2_i,
    input  logic [PHY_LOG-1:0] phy_dest_i,
    input  logic               phy_dest_valid_i,
    input  logic [AL_LOG-1:0]  al_id_i,
    output logic               busy_o,
    output logic               out_valid_o,
    output logic [DATA_W-1:0]  out_data_o,
    output logic [PHY_LOG-1:0] out_phy_dest_o,
    output logic               out_phy_dest_valid_o,
    output logic [AL_LOG-1:0]  out_al_id_o
);
    localparam int CNT_W = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    state_e stateReg, stateNext;
    logic [CNT_W-1:0]   count;
    logic               opRem, negQuo, negRem, tagPdv;
    logic [DATA_W-1:0]  divisor, rem, quo;
    logic [PHY_LOG-1:0] tagPhy;
    logic [AL_LOG-1:0]  tagAl;
    logic               accept, isSigned, s1, s2, divZero, ovf, special, stepOk, lastStep;
    logic [DATA_W-1:0]  mag1, mag2, specialData, remNext, quoNext, calcData;
    logic [DATA_W:0]    trial;
    assign busy_o = stateReg != IDLE;
    always_comb begin
        isSigned    = ~in_op_i[0];
        s1          = isSigned & src1_i[DATA_W-1];
        s2          = isSigned & src2_i[DATA_W-1];
        mag1        = s1 ? -src1_i : src1_i;
        mag2        = s2 ? -src2_i : src2_i;
        divZero     = src2_i == '0;
        ovf         = isSigned && src1_i == {1'b1, {(DATA_W-1){1'b0}}} && src2_i == '1;
        special     = divZero | ovf;
        specialData = divZero ? (in_op_i[1] ? src1_i : '1) : (in_op_i[1] ? '0 : src1_i);
        accept      = stateReg == IDLE && in_valid_i && !recover_i;
        // rem < divisor always holds, so a set rem MSB means the shifted value exceeds
        // the divisor and the step succeeds even though the borrow bit looks set
        trial       = {1'b0, rem[DATA_W-2:0], quo[DATA_W-1]} - {1'b0, divisor};
        stepOk      = rem[DATA_W-1] | ~trial[DATA_W];
        remNext     = stepOk ? trial[DATA_W-1:0] : {rem[DATA_W-2:0], quo[DATA_W-1]};
        quoNext     = {quo[DATA_W-2:0], stepOk};
        calcData    = opRem ? (negRem ? -remNext : remNext) : (negQuo ? -quoNext : quoNext);
        lastStep    = stateReg == CALC && count == CNT_W'(DATA_W - 1);
        stateNext   = stateReg;
        if (stateReg == IDLE && in_valid_i) stateNext = special ? DONE : CALC;
        if (lastStep) stateNext = DONE;
        if (stateReg == DONE) stateNext = IDLE;
        if (recover_i) stateNext = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg             <= IDLE;
            count                <= '0;
            opRem                <= 1'b0;
            negQuo               <= 1'b0;
            negRem               <= 1'b0;
            tagPdv               <= 1'b0;
            divisor              <= '0;
            rem                  <= '0;
            quo                  <= '0;
            tagPhy               <= '0;
            tagAl                <= '0;
            out_valid_o          <= 1'b0;
            out_data_o           <= '0;
            out_phy_dest_o       <= '0;
            out_phy_dest_valid_o <= 1'b0;
            out_al_id_o          <= '0;
        end else begin
            stateReg             <= stateNext;
            out_valid_o          <= 1'b0;
            out_phy_dest_valid_o <= 1'b0;
            if (accept) begin
                count   <= '0;
                opRem   <= in_op_i[1];
                negQuo  <= s1 ^ s2;
                negRem  <= s1;
                tagPdv  <= phy_dest_valid_i;
                tagPhy  <= phy_dest_i;
                tagAl   <= al_id_i;
                divisor <= mag2;
                rem     <= '0;
                quo     <= mag1;
                if (special) begin
                    out_valid_o          <= 1'b1;
                    out_data_o           <= specialData;
                    out_phy_dest_o       <= phy_dest_i;
                    out_phy_dest_valid_o <= phy_dest_valid_i;
                    out_al_id_o          <= al_id_i;
                end
            end
            if (stateReg == CALC && !recover_i) begin
                rem <= remNext;
                quo <= quoNext;
                if (lastStep) begin
                    out_valid_o          <= 1'b1;
                    out_data_o           <= calcData;
                    out_phy_dest_o       <= tagPhy;
                    out_phy_dest_valid_o <= tagPdv;
                    out_al_id_o          <= tagAl;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end
endmodule
